// File: rtl/utmi_pkt_tx.sv
// UTMI transmit packetizer: sends a PID byte, an optional payload stream and,
// for data PIDs, the inverted CRC16, then holds an inter-packet gap.
module utmi_pkt_tx #(
    parameter int unsigned IPG_CYCLES = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [3:0] pid_i,
    input  logic       has_data_i,
    output logic       start_ready_o,
    input  logic [7:0] in_data_i,
    input  logic       in_valid_i,
    input  logic       in_last_i,
    output logic       in_ready_o,
    output logic [7:0] utmi_data_out_o,
    output logic       utmi_txvalid_o,
    input  logic       utmi_txready_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PID    = 3'd1,
        ST_DATA   = 3'd2,
        ST_CRC_LO = 3'd3,
        ST_CRC_HI = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    localparam logic [7:0] IPG_LOAD = 8'(IPG_CYCLES);

    state_t      state_r, state_s;
    logic [7:0]  data_r, data_s;
    logic        txvalid_r, txvalid_s;
    logic [15:0] crc_r, crc_s;
    logic        crc_en_r, crc_en_s;
    logic        has_data_r, has_data_s;
    logic        last_taken_r, last_taken_s;
    logic [7:0]  gap_r, gap_s;
    logic        done_r, done_s;
    logic        err_r, err_s;
    logic        busy_r;
    logic        accept_s;
    logic        need_byte_s;

    // Reflected CRC16 (poly 0xA001), one byte consumed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) begin
                c = {1'b0, c[15:1]} ^ 16'hA001;
            end else begin
                c = {1'b0, c[15:1]};
            end
        end
        return c;
    endfunction

    // Handshake qualifiers; in_ready is combinational from utmi_txready_i.
    always_comb begin
        accept_s    = txvalid_r & utmi_txready_i;
        need_byte_s = accept_s & has_data_r & ~last_taken_r &
                      ((state_r == ST_PID) | (state_r == ST_DATA));
        in_ready_o  = need_byte_s & in_valid_i;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s      = state_r;
        data_s       = data_r;
        txvalid_s    = txvalid_r;
        crc_s        = crc_r;
        crc_en_s     = crc_en_r;
        has_data_s   = has_data_r;
        last_taken_s = last_taken_r;
        gap_s        = gap_r;
        done_s       = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    data_s       = {~pid_i, pid_i};
                    txvalid_s    = 1'b1;
                    crc_en_s     = (pid_i[1:0] == 2'b11);
                    has_data_s   = has_data_i;
                    last_taken_s = 1'b0;
                    crc_s        = 16'hFFFF;
                    state_s      = ST_PID;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PID, ST_DATA: begin
                if (!accept_s) begin
                    state_s = state_r;
                end else if (need_byte_s) begin
                    if (in_valid_i) begin
                        data_s       = in_data_i;
                        crc_s        = crc16_byte(crc_r, in_data_i);
                        last_taken_s = in_last_i;
                        state_s      = ST_DATA;
                    end else begin
                        // Underrun: abandon the packet without a CRC.
                        data_s    = 8'h00;
                        txvalid_s = 1'b0;
                        err_s     = 1'b1;
                        gap_s     = IPG_LOAD;
                        state_s   = ST_GAP;
                    end
                end else if (crc_en_r) begin
                    data_s  = ~crc_r[7:0];
                    state_s = ST_CRC_LO;
                end else begin
                    data_s    = 8'h00;
                    txvalid_s = 1'b0;
                    done_s    = 1'b1;
                    gap_s     = IPG_LOAD;
                    state_s   = ST_GAP;
                end
            end
            ST_CRC_LO: begin
                if (accept_s) begin
                    data_s  = ~crc_r[15:8];
                    state_s = ST_CRC_HI;
                end else begin
                    state_s = ST_CRC_LO;
                end
            end
            ST_CRC_HI: begin
                if (accept_s) begin
                    data_s    = 8'h00;
                    txvalid_s = 1'b0;
                    done_s    = 1'b1;
                    gap_s     = IPG_LOAD;
                    state_s   = ST_GAP;
                end else begin
                    state_s = ST_CRC_HI;
                end
            end
            ST_GAP: begin
                if (gap_r <= 8'd1) begin
                    gap_s   = 8'd0;
                    state_s = ST_IDLE;
                end else begin
                    gap_s = gap_r - 8'd1;
                end
            end
            default: begin
                txvalid_s = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            data_r       <= 8'h00;
            txvalid_r    <= 1'b0;
            crc_r        <= 16'hFFFF;
            crc_en_r     <= 1'b0;
            has_data_r   <= 1'b0;
            last_taken_r <= 1'b0;
            gap_r        <= 8'd0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            data_r       <= data_s;
            txvalid_r    <= txvalid_s;
            crc_r        <= crc_s;
            crc_en_r     <= crc_en_s;
            has_data_r   <= has_data_s;
            last_taken_r <= last_taken_s;
            gap_r        <= gap_s;
            done_r       <= done_s;
            err_r        <= err_s;
            busy_r       <= (state_s != ST_IDLE);
        end
    end

    assign start_ready_o   = (state_r == ST_IDLE);
    assign utmi_data_out_o = data_r;
    assign utmi_txvalid_o  = txvalid_r;
    assign busy_o          = busy_r;
    assign done_o          = done_r;
    assign err_o           = err_r;

endmodule

// File: doc/utmi_pkt_tx.md
# utmi_pkt_tx

Transmit-side USB packetizer for the ULPI/UTMI path: it is the sender that complements the existing receive-only UTMI datapath. Accepts a packet request (PID plus an optional byte stream), drives the UTMI transmit interface (`utmi_data_out`/`utmi_txvalid`/`utmi_txready`) toward the ULPI wrapper, and appends CRC16 to data packets. Runs entirely in the 60 MHz ULPI clock domain.

## Interface
- `IPG_CYCLES`, 8: idle cycles enforced after `utmi_txvalid_o` falls before the next request is accepted (1..255).
- `clk_i` in 1: ULPI 60 MHz clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `start_i` in 1: packet request; accepted only when `start_ready_o`=1.
- `pid_i` in 4: USB PID; sampled when accepted.
- `has_data_i` in 1: payload follows on the stream; sampled when accepted.
- `start_ready_o` out 1: high in IDLE only.
- `in_data_i` in 8: payload byte.
- `in_valid_i` in 1: payload byte valid.
- `in_last_i` in 1: final payload byte.
- `in_ready_o` out 1: payload byte consumed this cycle.
- `utmi_data_out_o` out 8: UTMI transmit byte.
- `utmi_txvalid_o` out 1: UTMI transmit valid.
- `utmi_txready_i` in 1: PHY accepted the current byte.
- `busy_o` out 1: not IDLE.
- `done_o` out 1: one-cycle pulse; packet completed normally.
- `err_o` out 1: one-cycle pulse; packet aborted on underrun.

## Operation
- Reset values: `utmi_data_out_o`=0x00, `utmi_txvalid_o`=0, `in_ready_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0, `start_ready_o`=1. CRC register=0xFFFF. State=IDLE.
- States: IDLE, PID, DATA, CRC_LO, CRC_HI, GAP.
- **IDLE**
  - On `start_i`, register the PID byte `{~pid_i, pid_i}`.
  - Set `crc_en = (pid_i[1:0]==2'b11)`; this is true for DATA0/1/2/MDATA.
  - Set CRC=0xFFFF and go to PID.
- **PID**
  - Hold `utmi_txvalid_o`=1 with the PID byte until `utmi_txready_i`.
  - On acceptance with `has_data`: take the stream byte and go to DATA.
  - On acceptance without `has_data`: go to CRC_LO if `crc_en`, else end.
- **DATA**
  - Hold the current byte until `utmi_txready_i`.
  - On acceptance with the last byte already taken: go to CRC_LO if `crc_en`, else end.
  - On acceptance otherwise: take the next stream byte.
- **Stream take**
  - `in_ready_o = utmi_txvalid_o & utmi_txready_i & in_valid_i & has_data & ~last_taken`, asserted in PID or DATA only. It is combinational from `utmi_txready_i`.
  - When `in_ready_o`=1: register `in_data_i`, update CRC with that byte, and set `last_taken` from `in_last_i`.
- **Underrun**
  - Condition: a byte is needed (acceptance in PID/DATA with `has_data` and not `last_taken`) but `in_valid_i`=0.
  - Response: drop `utmi_txvalid_o` the next cycle, pulse `err_o`, go to GAP. No CRC is sent.
- **CRC16**
  - Reflected polynomial 0xA001, LSB-first byte update.
  - Transmitted value is `~crc`: CRC_LO sends bits [7:0], then CRC_HI sends bits [15:8]. Each byte is held until `utmi_txready_i`.
- **End**
  - The cycle after the final byte is accepted: `utmi_txvalid_o`=0 and `done_o` pulses.
  - Go to GAP with a counter loaded to `IPG_CYCLES`.
  - GAP decrements to 0, then returns to IDLE.
- Handshake and token PIDs carry no CRC16. Tokens supply their 2 bytes, CRC5 included, through the stream with `has_data_i`=1.
- `start_i` outside IDLE is ignored. Stream bytes are never consumed outside PID/DATA.
- `rst_ni` low mid-packet returns all outputs to reset values immediately (asynchronous). No done/err pulse is generated.

## Timing
- Request accepted at cycle N → `utmi_txvalid_o`=1 with the PID byte at N+1.
- A byte advances only on a cycle where `utmi_txvalid_o & utmi_txready_i`. Data and valid are otherwise stable, including when `utmi_txready_i` is held low indefinitely.
- Back-to-back bytes are sustained when `utmi_txready_i` is continuously high and `in_valid_i` is high: zero bubbles.
- Last accepted byte at cycle M → `utmi_txvalid_o`=0 and `done_o`=1 at M+1. `start_ready_o`=1 at M+1+`IPG_CYCLES`.
- All outputs are registered except `in_ready_o` and `start_ready_o`.

## Test plan
- **ACK handshake:** `pid_i`=0x2, `has_data_i`=0, `utmi_txready_i`=1 → one byte 0xD2, txvalid high for 1 cycle, `done_o` pulses, no `in_ready_o`.
- **Zero-length DATA0:** `pid_i`=0x3, `has_data_i`=0 → bytes 0xC3, 0x00, 0x00, then `done_o`.
- **DATA1 payload:** `pid_i`=0xB, payload 0x00,0x01,0x02,0x03 → 0x4B, payload, CRC bytes matching the bench reference CRC16 model.
- **Throttle:** same DATA1 packet with random `utmi_txready_i` → identical byte sequence, and no byte changes while txready is low.
- **Underrun:** DATA0 with `in_valid_i` dropped after 2 bytes → txvalid falls after byte 2 is accepted, `err_o` pulses, no CRC, and the next start is accepted only after `IPG_CYCLES`.
- **Reset mid-packet:** assert `rst_ni` during DATA → txvalid=0 and busy=0 asynchronously. After release, a new ACK transmits normally.
